audio_adc_rx: RTL

// - Multi-channel serial audio ADC receiver (left-justified, I2S, TDM), parametrised successor of the stereo 16-bit capture block.
// - Deserialises AUD_ADC_DATA on AUD_BCLK and aligns slots to the AUD_ADC_CLK frame clock.
// - Pushes one packed frame per write into the dual-clock sample FIFO.
// - Reports FIFO overflow and frame-sync errors to the control logic.

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_slot_shifter.sv | 25 ++
 rtl/audio_adc_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the serial audio ADC receiver.
package audio_pkg;

  // Data alignment relative to the frame-clock edge.
  typedef enum logic [0:0] {
    AUD_MODE_LJ  = 1'b0,  // first sample bit in the edge cycle
    AUD_MODE_I2S = 1'b1   // first sample bit one BCLK after the edge
  } aud_mode_e;

  localparam int AUD_MAX_CHANNELS     = 8;
  localparam int AUD_DEF_SAMPLE_WIDTH = 16;
  localparam int AUD_DEF_SLOT_WIDTH   = 32;

  // Width of a channel index; never narrower than one bit.
  function automatic int aud_idx_width(input int num_channels);
    return (num_channels > 2) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/audio_slot_shifter.sv
// One channel's MSB-first serial-to-parallel capture register.
module audio_slot_shifter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUD_DEF_SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    shift_en,
  input  logic                    serial_in,
  output logic [SAMPLE_WIDTH-1:0] word
);

  // Shift the serial bit in at the LSB while the capture window is open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[SAMPLE_WIDTH-2:0], serial_in};
    end else begin
      word <= word;
    end
  end

endmodule

// File: rtl/audio_adc_rx.sv
// Multi-channel serial audio ADC receiver: frame-clock alignment, per-channel
// capture, one packed FIFO write per frame, overflow and frame-sync reporting.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int        SAMPLE_WIDTH = AUD_DEF_SAMPLE_WIDTH,
  parameter int        SLOT_WIDTH   = AUD_DEF_SLOT_WIDTH,
  parameter int        NUM_CHANNELS = 2,
  parameter aud_mode_e MODE         = AUD_MODE_LJ,
  parameter int        OVF_WIDTH    = 8
) (
  input  logic                                 AUD_BCLK,
  input  logic                                 reset_n,
  input  logic                                 AUD_ADC_CLK,
  input  logic                                 AUD_ADC_DATA,
  input  logic                                 wrfull_sig,
  input  logic                                 clr_status,
  output logic                                 wrreq_sig,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_sig,
  output logic [OVF_WIDTH-1:0]                 overflow_cnt,
  output logic                                 sync_err
);

  localparam int                   BW       = $clog2(SLOT_WIDTH);
  localparam int                   CW       = aud_idx_width(NUM_CHANNELS);
  localparam int                   FW       = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam bit                   STEREO   = (NUM_CHANNELS == 2);
  localparam int                   WIN_LO   = int'(MODE);
  localparam int                   WIN_HI   = WIN_LO + SAMPLE_WIDTH - 1;
  localparam logic [BW-1:0]        LAST_BIT = BW'(SLOT_WIDTH - 1);
  localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
  localparam logic [CW-1:0]        LAST_CH  = CW'(NUM_CHANNELS - 1);
  localparam logic [CW-1:0]        CH_ONE   = CW'(1);
  localparam logic [OVF_WIDTH-1:0] OVF_MAX  = '1;
  localparam logic [OVF_WIDTH-1:0] OVF_ONE  = OVF_WIDTH'(1);

  if (SAMPLE_WIDTH + int'(MODE) > SLOT_WIDTH) begin : g_bad_slot
    $error("audio_adc_rx: SAMPLE_WIDTH+MODE exceeds SLOT_WIDTH");
  end
  if (NUM_CHANNELS < 2 || NUM_CHANNELS > AUD_MAX_CHANNELS) begin : g_bad_ch
    $error("audio_adc_rx: NUM_CHANNELS must be 2..8");
  end

  // Registered slot state
  logic          lrck_q;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] ch_idx;
  logic          locked;
  logic          frame_ok;   // current frame is clean and may still commit
  logic          committed;  // current frame has already been written

  // Combinational view of the current cycle
  logic          rise, fall;
  logic [BW-1:0] eff_bit, bit_nxt;
  logic [CW-1:0] eff_ch, ch_nxt;
  logic          lock_nxt, frame_ok_nxt, committed_cur;
  logic          rise_err, fall_err, sync_evt;
  logic          in_win, cap_en, commit, ovf_evt;
  logic [FW-1:0] frame_now;
  logic [SAMPLE_WIDTH-1:0] words [NUM_CHANNELS];

  // Edge detection, slot position of this cycle and frame bookkeeping.
  always_comb begin
    rise    = AUD_ADC_CLK & ~lrck_q;
    fall    = STEREO & ~AUD_ADC_CLK & lrck_q;
    eff_bit = bit_cnt;
    eff_ch  = ch_idx;
    if (rise) begin
      eff_bit = '0;
      eff_ch  = '0;
    end else if (fall) begin
      eff_bit = '0;
      eff_ch  = CH_ONE;
    end else begin
      eff_bit = bit_cnt;
      eff_ch  = ch_idx;
    end

    if (eff_bit == LAST_BIT) begin
      bit_nxt = '0;
      ch_nxt  = (eff_ch == LAST_CH) ? eff_ch : eff_ch + CH_ONE;
    end else begin
      bit_nxt = eff_bit + BIT_ONE;
      ch_nxt  = eff_ch;
    end

    // A normal left slot hands over to channel 1 exactly as LRCK falls, so a
    // fall is only misaligned once the counters have moved past that point.
    rise_err = rise & locked & frame_ok & ~committed;
    fall_err = fall & locked &
               ~((ch_idx == '0) | ((ch_idx == CH_ONE) & (bit_cnt == '0)));
    sync_evt = rise_err | fall_err;
    lock_nxt = locked | rise;

    if (rise) begin
      frame_ok_nxt  = 1'b1;
      committed_cur = 1'b0;
    end else if (fall_err) begin
      frame_ok_nxt  = 1'b0;
      committed_cur = committed;
    end else begin
      frame_ok_nxt  = frame_ok;
      committed_cur = committed;
    end

    in_win  = (int'(eff_bit) >= WIN_LO) && (int'(eff_bit) <= WIN_HI);
    cap_en  = lock_nxt & frame_ok_nxt & in_win;
    commit  = cap_en & (eff_ch == LAST_CH) & (int'(eff_bit) == WIN_HI) & ~committed_cur;
    ovf_evt = commit & wrfull_sig;
  end

  // Pack all channels, folding in the last bit arriving this cycle.
  always_comb begin
    frame_now = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      frame_now[(NUM_CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = words[c];
    end
    frame_now[SAMPLE_WIDTH-1:0] = {words[NUM_CHANNELS-1][SAMPLE_WIDTH-2:0], AUD_ADC_DATA};
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    audio_slot_shifter #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_shift (
      .clk       (AUD_BCLK),
      .reset_n   (reset_n),
      .shift_en  (cap_en & (eff_ch == CW'(g))),
      .serial_in (AUD_ADC_DATA),
      .word      (words[g])
    );
  end

  // Advance the slot counters and frame lock/commit state.
  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      lrck_q    <= 1'b0;
      bit_cnt   <= '0;
      ch_idx    <= '0;
      locked    <= 1'b0;
      frame_ok  <= 1'b0;
      committed <= 1'b0;
    end else begin
      lrck_q    <= AUD_ADC_CLK;
      bit_cnt   <= bit_nxt;
      ch_idx    <= ch_nxt;
      locked    <= lock_nxt;
      frame_ok  <= frame_ok_nxt;
      committed <= committed_cur | commit;
    end
  end

  // Present the completed frame and pulse the FIFO write when there is room.
  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      wrreq_sig <= 1'b0;
      data_sig  <= '0;
    end else begin
      wrreq_sig <= commit & ~wrfull_sig;
      if (commit) begin
        data_sig <= frame_now;
      end else begin
        data_sig <= data_sig;
      end
    end
  end

  // Status: saturating drop counter and sticky sync flag; events beat clears.
  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
      sync_err     <= 1'b0;
    end else begin
      if (ovf_evt) begin
        if (clr_status) begin
          overflow_cnt <= OVF_ONE;
        end else if (overflow_cnt == OVF_MAX) begin
          overflow_cnt <= overflow_cnt;
        end else begin
          overflow_cnt <= overflow_cnt + OVF_ONE;
        end
      end else if (clr_status) begin
        overflow_cnt <= '0;
      end else begin
        overflow_cnt <= overflow_cnt;
      end

      if (sync_evt) begin
        sync_err <= 1'b1;
      end else if (clr_status) begin
        sync_err <= 1'b0;
      end else begin
        sync_err <= sync_err;
      end
    end
  end

endmodule
